// File: rtl/mc_main_ctrl.sv
//==============================================================================
// Module   : mc_main_ctrl
// Brief    : Main control FSM for the multi-cycle MIPS datapath. Steps the
//            shared PC/memory/IR/regfile/ALU datapath one state per cycle,
//            decodes IR[31:26] and the ALU Zero flag, and stalls fetch and
//            data accesses on the mem_req/mem_ready handshake.
// Options  : `define MC_CTRL_BNE_EN adds the BNE branch state (encoding 13);
//            without it OP_BNE decodes as an illegal opcode.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module mc_main_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_LW    = 6'h23,
    parameter logic [5:0] OP_SW    = 6'h2B,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_ADDI  = 6'h08,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_BNE   = 6'h05
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXECUTE = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JUMP    = 4'd12,
        S_BNE     = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_dec_illegal;
    logic       w_pcen;

    logic       r_mem_req;
    logic       r_iord;
    logic       r_memwrite;
    logic       r_regdst;
    logic       r_memtoreg;
    logic       r_regwrite;
    logic       r_alusrca;
    logic [1:0] r_alusrcb;
    logic [1:0] r_aluop;
    logic [1:0] r_pcsrc;
    logic       r_illegal;

    // Next-state selection; also flags an unsupported opcode seen in DECODE.
    always_comb begin
        w_next        = S_FETCH;
        w_dec_illegal = 1'b0;
        case (r_state)
            S_RESET:   w_next = S_FETCH;
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTE;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BNE;
`else
                    OP_BNE: begin
                        w_next        = S_FETCH;
                        w_dec_illegal = 1'b1;
                    end
`endif
                    default: begin
                        w_next        = S_FETCH;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Op == OP_LW)
                    w_next = S_MEMRD;
                else if (Op == OP_SW)
                    w_next = S_MEMWR;
                else
                    w_next = S_FETCH;
            end
            S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: w_next = S_ALUWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    // State register plus Moore outputs registered from the upcoming state,
    // so every decoded control line comes straight off a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_mem_req  <= 1'b0;
            r_iord     <= 1'b0;
            r_memwrite <= 1'b0;
            r_regdst   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_alusrca  <= 1'b0;
            r_alusrcb  <= 2'b00;
            r_aluop    <= 2'b00;
            r_pcsrc    <= 2'b00;
            r_illegal  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_illegal  <= w_dec_illegal;
            r_mem_req  <= 1'b0;
            r_iord     <= 1'b0;
            r_memwrite <= 1'b0;
            r_regdst   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_alusrca  <= 1'b0;
            r_alusrcb  <= 2'b00;
            r_aluop    <= 2'b00;
            r_pcsrc    <= 2'b00;
            case (w_next)
                S_FETCH: begin
                    r_mem_req <= 1'b1;
                    r_alusrcb <= 2'b01;
                end
                S_DECODE:  r_alusrcb <= 2'b11;
                S_MEMADR: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                S_MEMRD: begin
                    r_mem_req <= 1'b1;
                    r_iord    <= 1'b1;
                end
                S_MEMWB: begin
                    r_memtoreg <= 1'b1;
                    r_regwrite <= 1'b1;
                end
                S_MEMWR: begin
                    r_mem_req  <= 1'b1;
                    r_iord     <= 1'b1;
                    r_memwrite <= 1'b1;
                end
                S_EXECUTE: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= 2'b10;
                end
                S_ALUWB: begin
                    r_regdst   <= 1'b1;
                    r_regwrite <= 1'b1;
                end
                S_BRANCH, S_BNE: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= 2'b01;
                    r_pcsrc   <= 2'b01;
                end
                S_ADDIEX: begin
                    r_alusrca <= 1'b1;
                    r_alusrcb <= 2'b10;
                end
                S_ADDIWB:  r_regwrite <= 1'b1;
                S_JUMP:    r_pcsrc <= 2'b10;
                default: ;
            endcase
        end
    end

    // PC load enable depends on same-cycle handshake and Zero flag.
    always_comb begin
        w_pcen = 1'b0;
        case (r_state)
            S_FETCH:  w_pcen = mem_ready;
            S_BRANCH: w_pcen = Zero;
            S_JUMP:   w_pcen = 1'b1;
`ifdef MC_CTRL_BNE_EN
            S_BNE:    w_pcen = ~Zero;
`endif
            default:  w_pcen = 1'b0;
        endcase
    end

    assign IRWrite    = (r_state == S_FETCH) && mem_ready;
    assign PCEn       = w_pcen;
    assign mem_req    = r_mem_req;
    assign IorD       = r_iord;
    assign MemWrite   = r_memwrite;
    assign RegDst     = r_regdst;
    assign MemtoReg   = r_memtoreg;
    assign RegWrite   = r_regwrite;
    assign ALUSrcA    = r_alusrca;
    assign ALUSrcB    = r_alusrcb;
    assign ALUOp      = r_aluop;
    assign PCSrc      = r_pcsrc;
    assign illegal_op = r_illegal;
    assign state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
//==============================================================================
// Module   : tb_mc_main_ctrl
// Brief    : Scoreboard bench for mc_main_ctrl. Stimulus drives one cycle at a
//            time and queues the hand-written expected state/control word; an
//            independent monitor pops and compares on every falling edge.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic       Zero;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, PCEn, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;

    mc_main_ctrl dut (
        .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
        .PCEn(PCEn), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Control word: {state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    //                RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op}
    function automatic logic [19:0] cw(input logic [3:0] st,
        input logic mreq, input logic iord, input logic mw, input logic irw,
        input logic rd, input logic m2r, input logic rw, input logic sa,
        input logic [1:0] sb, input logic [1:0] ao, input logic [1:0] pcs,
        input logic pce, input logic ill);
        return {st, mreq, iord, mw, irw, rd, m2r, rw, sa, sb, ao, pcs, pce, ill};
    endfunction

    // Hand-derived expected words per state.
    function automatic logic [19:0] e_reset();       return cw(4'd0, 0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_fetch(input logic mr, input logic ill);
                                                     return cw(4'd1, 1,0,0,mr,0,0,0,0, 2'b01,2'b00,2'b00, mr,ill); endfunction
    function automatic logic [19:0] e_decode();      return cw(4'd2, 0,0,0,0,0,0,0,0, 2'b11,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_memadr();      return cw(4'd3, 0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_memrd();       return cw(4'd4, 1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_memwb();       return cw(4'd5, 0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_memwr();       return cw(4'd6, 1,1,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_execute();     return cw(4'd7, 0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_aluwb();       return cw(4'd8, 0,0,0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_branch(input logic pce);
                                                     return cw(4'd9, 0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, pce,0); endfunction
    function automatic logic [19:0] e_addiex();      return cw(4'd10,0,0,0,0,0,0,0,1, 2'b10,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_addiwb();      return cw(4'd11,0,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 0,0); endfunction
    function automatic logic [19:0] e_jump();        return cw(4'd12,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b10, 1,0); endfunction

    // Drive one cycle of inputs (just after a rising edge) and queue its expectation.
    task automatic step(input string name, input logic r, input logic [5:0] op,
                        input logic z, input logic mr, input logic [19:0] exp);
        rst       = r;
        Op        = op;
        Zero      = z;
        mem_ready = mr;
        q.push_back('{name, exp});
        @(posedge clk);
        #1;
    endtask

    // Monitor: one comparison per falling edge whenever an expectation is pending.
    initial begin
        exp_t        e;
        logic [19:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {state_o, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg,
                       RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op};
                n_checks++;
                if (act === e.exp)
                    n_pass++;
                else
                    $display("FAIL %s: got %05h expected %05h", e.name, act, e.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; Op = 6'h00; Zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        // Reset hold and release.
        step("reset_hold",  1, 6'h00, 0, 0, e_reset());
        step("reset_rel",   0, 6'h00, 0, 0, e_reset());
        // lw with one stalled fetch cycle.
        step("lw_fetch_st", 0, 6'h23, 0, 0, e_fetch(0, 0));
        step("lw_fetch",    0, 6'h23, 0, 1, e_fetch(1, 0));
        step("lw_decode",   0, 6'h23, 0, 1, e_decode());
        step("lw_memadr",   0, 6'h23, 0, 1, e_memadr());
        step("lw_memrd",    0, 6'h23, 0, 1, e_memrd());
        step("lw_memwb",    0, 6'h23, 0, 1, e_memwb());
        // sw with three stalled write cycles.
        step("sw_fetch",    0, 6'h2B, 0, 1, e_fetch(1, 0));
        step("sw_decode",   0, 6'h2B, 0, 1, e_decode());
        step("sw_memadr",   0, 6'h2B, 0, 1, e_memadr());
        step("sw_memwr0",   0, 6'h2B, 0, 0, e_memwr());
        step("sw_memwr1",   0, 6'h2B, 0, 0, e_memwr());
        step("sw_memwr2",   0, 6'h2B, 0, 0, e_memwr());
        step("sw_memwr3",   0, 6'h2B, 0, 1, e_memwr());
        // beq taken, then not taken.
        step("beq1_fetch",  0, 6'h04, 1, 1, e_fetch(1, 0));
        step("beq1_decode", 0, 6'h04, 1, 1, e_decode());
        step("beq1_branch", 0, 6'h04, 1, 1, e_branch(1));
        step("beq0_fetch",  0, 6'h04, 0, 1, e_fetch(1, 0));
        step("beq0_decode", 0, 6'h04, 0, 1, e_decode());
        step("beq0_branch", 0, 6'h04, 0, 1, e_branch(0));
        // R-type then addi.
        step("r_fetch",     0, 6'h00, 0, 1, e_fetch(1, 0));
        step("r_decode",    0, 6'h00, 0, 1, e_decode());
        step("r_execute",   0, 6'h00, 0, 1, e_execute());
        step("r_aluwb",     0, 6'h00, 0, 1, e_aluwb());
        step("addi_fetch",  0, 6'h08, 0, 1, e_fetch(1, 0));
        step("addi_decode", 0, 6'h08, 0, 1, e_decode());
        step("addi_ex",     0, 6'h08, 0, 1, e_addiex());
        step("addi_wb",     0, 6'h08, 0, 1, e_addiwb());
        // Jump.
        step("j_fetch",     0, 6'h02, 0, 1, e_fetch(1, 0));
        step("j_decode",    0, 6'h02, 0, 1, e_decode());
        step("j_jump",      0, 6'h02, 0, 1, e_jump());
        // Opcode 05: BNE when enabled, otherwise illegal.
        step("bne_fetch",   0, 6'h05, 0, 1, e_fetch(1, 0));
        step("bne_decode",  0, 6'h05, 0, 1, e_decode());
`ifdef MC_CTRL_BNE_EN
        step("bne_state",   0, 6'h05, 0, 1, cw(4'd13, 0,0,0,0,0,0,0,1, 2'b00,2'b01,2'b01, 1,0));
        step("bne_ret",     0, 6'h3F, 0, 1, e_fetch(1, 0));
`else
        step("bne_ill",     0, 6'h3F, 0, 1, e_fetch(1, 1));
`endif
        // Unknown opcode 3F: one-cycle illegal pulse, then normal decode.
        step("ill_decode",  0, 6'h3F, 0, 1, e_decode());
        step("ill_pulse",   0, 6'h02, 0, 1, e_fetch(1, 1));
        step("ill_clear",   0, 6'h02, 0, 1, e_decode());
        step("ill_jump",    0, 6'h02, 0, 1, e_jump());
        // Reset in the middle of a stalled store.
        step("rs_fetch",    0, 6'h2B, 0, 1, e_fetch(1, 0));
        step("rs_decode",   0, 6'h2B, 0, 1, e_decode());
        step("rs_memadr",   0, 6'h2B, 0, 0, e_memadr());
        step("rs_memwr",    0, 6'h2B, 0, 0, e_memwr());
        step("rs_async",    1, 6'h2B, 0, 0, e_reset());
        step("rs_release",  0, 6'h2B, 0, 0, e_reset());
        step("rs_fetch2",   0, 6'h2B, 0, 1, e_fetch(1, 0));

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
